// File: rtl/fifo_pkg.sv
// Shared types and constants for the parametrised valid/ready FIFO.
package fifo_pkg;

  typedef logic [31:0] data_t;

  localparam int unsigned MinDepth = 2;
  localparam int unsigned MaxDepth = 1024;

  // Count must represent 0..depth inclusive, hence depth + 1 states.
  function automatic int unsigned calc_cw(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x data_t registers, one write port, one asynchronous read port, no reset.
module fifo_mem #(
  parameter int unsigned DEPTH = 4,
  parameter type data_t = fifo_pkg::data_t,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  data_t         wdata_i,
  input  logic [AW-1:0] raddr_i,
  output data_t         rdata_o
);

  data_t mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fifo_top_v2.sv
// Single-clock valid/ready FIFO with arbitrary depth, occupancy count, runtime almost-full/empty
// thresholds, synchronous flush and a high-watermark monitor.
module fifo_top_v2
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type data_t = fifo_pkg::data_t,
  localparam int unsigned CW = calc_cw(DEPTH)
) (
  input  logic          clk_i,
  input  logic          arst_ni,
  input  data_t         data_i,
  input  logic          data_valid_i,
  output logic          data_ready_o,
  output data_t         data_o,
  output logic          data_valid_o,
  input  logic          data_ready_i,
  input  logic          flush_i,
  input  logic [CW-1:0] afull_thresh_i,
  input  logic [CW-1:0] aempty_thresh_i,
  output logic          isFull_o,
  output logic          isEmpty_o,
  output logic          isAlmostFull_o,
  output logic          isAlmostEmpty_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] watermark_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, wm_q, wm_d;
  logic          full, empty, push, pop;

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic logic [AW-1:0] ptr_inc(logic [AW-1:0] p);
    return (p == LastIdx) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == DepthC);
  assign empty = (count_q == '0);
  assign push  = data_valid_i & ~full;
  assign pop   = data_ready_i & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wm_d     = wm_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      wm_d     = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
      if (count_d > wm_q) wm_d = count_d;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wm_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wm_q     <= wm_d;
    end
  end

  // A flushed push is dropped, so it must not disturb storage either.
  fifo_mem #(
    .DEPTH (DEPTH),
    .data_t(data_t)
  ) u_mem (
    .clk_i  (clk_i),
    .we_i   (push & ~flush_i),
    .waddr_i(wr_ptr_q),
    .wdata_i(data_i),
    .raddr_i(rd_ptr_q),
    .rdata_o(data_o)
  );

  assign data_ready_o    = ~full;
  assign data_valid_o    = ~empty;
  assign isFull_o        = full;
  assign isEmpty_o       = empty;
  assign isAlmostFull_o  = (count_q >= afull_thresh_i);
  assign isAlmostEmpty_o = (count_q <= aempty_thresh_i);
  assign count_o         = count_q;
  assign watermark_o     = wm_q;

  a_depth_range: assert property (@(posedge clk_i)
    (DEPTH >= MinDepth) && (DEPTH <= MaxDepth));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!arst_ni) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!arst_ni) !(pop && empty));
  a_count_max: assert property (@(posedge clk_i) disable iff (!arst_ni) count_q <= DepthC);

endmodule

// File: tb/tb_fifo_top_v2.sv
// Bench for fifo_top_v2: DEPTH=4 and DEPTH=5 instances share stimulus; queue models check both.
module tb_fifo_top_v2;

  logic        clk, arst_n;
  logic [31:0] din;
  logic        v_in, r_in, flush;
  logic [2:0]  afull_thr, aempty_thr;

  logic [31:0] o4_data, o5_data;
  logic        o4_rdy, o4_vld, o4_full, o4_empty, o4_af, o4_ae;
  logic        o5_rdy, o5_vld, o5_full, o5_empty, o5_af, o5_ae;
  logic [2:0]  o4_count, o4_wm, o5_count, o5_wm;

  int total = 0;
  int bad   = 0;

  fifo_top_v2 #(.DEPTH(4)) u_dut4 (
    .clk_i(clk), .arst_ni(arst_n), .data_i(din), .data_valid_i(v_in), .data_ready_o(o4_rdy),
    .data_o(o4_data), .data_valid_o(o4_vld), .data_ready_i(r_in), .flush_i(flush),
    .afull_thresh_i(afull_thr), .aempty_thresh_i(aempty_thr), .isFull_o(o4_full),
    .isEmpty_o(o4_empty), .isAlmostFull_o(o4_af), .isAlmostEmpty_o(o4_ae),
    .count_o(o4_count), .watermark_o(o4_wm)
  );

  fifo_top_v2 #(.DEPTH(5)) u_dut5 (
    .clk_i(clk), .arst_ni(arst_n), .data_i(din), .data_valid_i(v_in), .data_ready_o(o5_rdy),
    .data_o(o5_data), .data_valid_o(o5_vld), .data_ready_i(r_in), .flush_i(flush),
    .afull_thresh_i(afull_thr), .aempty_thresh_i(aempty_thr), .isFull_o(o5_full),
    .isEmpty_o(o5_empty), .isAlmostFull_o(o5_af), .isAlmostEmpty_o(o5_ae),
    .count_o(o5_count), .watermark_o(o5_wm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference models: a queue of stored words plus the peak size seen.
  logic [31:0] m4q[$];
  logic [31:0] m5q[$];
  int m4wm = 0;
  int m5wm = 0;

  always @(posedge clk or negedge arst_n) begin
    bit pu, po;
    if (!arst_n || flush) begin
      m4q.delete();
      m4wm <= 0;
    end else begin
      pu = v_in && (m4q.size() < 4);
      po = r_in && (m4q.size() > 0);
      if (po) void'(m4q.pop_front());
      if (pu) m4q.push_back(din);
      if (m4q.size() > m4wm) m4wm <= m4q.size();
    end
  end

  always @(posedge clk or negedge arst_n) begin
    bit pu, po;
    if (!arst_n || flush) begin
      m5q.delete();
      m5wm <= 0;
    end else begin
      pu = v_in && (m5q.size() < 5);
      po = r_in && (m5q.size() > 0);
      if (po) void'(m5q.pop_front());
      if (pu) m5q.push_back(din);
      if (m5q.size() > m5wm) m5wm <= m5q.size();
    end
  end

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(string tag, int depth, int cnt, bit full, bit empty, bit vld,
                           bit rdy, bit af, bit ae, int wm, logic [31:0] dout, int mcnt,
                           int mwm, logic [31:0] mhead);
    chk({tag, ".count"}, cnt, mcnt);
    chk({tag, ".full"}, full, int'(mcnt == depth));
    chk({tag, ".empty"}, empty, int'(mcnt == 0));
    chk({tag, ".valid"}, vld, int'(mcnt != 0));
    chk({tag, ".ready"}, rdy, int'(mcnt != depth));
    chk({tag, ".afull"}, af, int'(mcnt >= int'(afull_thr)));
    chk({tag, ".aempty"}, ae, int'(mcnt <= int'(aempty_thr)));
    chk({tag, ".watermark"}, wm, mwm);
    if (mcnt > 0) chk({tag, ".data"}, int'(dout), int'(mhead));
  endtask

  task automatic check_all();
    check_dut("d4", 4, o4_count, o4_full, o4_empty, o4_vld, o4_rdy, o4_af, o4_ae, o4_wm,
              o4_data, m4q.size(), m4wm, (m4q.size() > 0) ? m4q[0] : 32'h0);
    check_dut("d5", 5, o5_count, o5_full, o5_empty, o5_vld, o5_rdy, o5_af, o5_ae, o5_wm,
              o5_data, m5q.size(), m5wm, (m5q.size() > 0) ? m5q[0] : 32'h0);
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    bit v; bit r; logic [31:0] d;
    int c; bit f; bit ae; bit af; int wm; logic [31:0] head;
  } vec_t;

  vec_t tbl [11];
  int   hs;

  initial begin
    // Fill DEPTH=4 past full with the consumer stalled, release one slot, then drain.
    tbl[0]  = '{1'b1, 1'b0, 32'hA0, 1, 1'b0, 1'b1, 1'b0, 1, 32'hA0};
    tbl[1]  = '{1'b1, 1'b0, 32'hA1, 2, 1'b0, 1'b0, 1'b0, 2, 32'hA0};
    tbl[2]  = '{1'b1, 1'b0, 32'hA2, 3, 1'b0, 1'b0, 1'b1, 3, 32'hA0};
    tbl[3]  = '{1'b1, 1'b0, 32'hA3, 4, 1'b1, 1'b0, 1'b1, 4, 32'hA0};
    tbl[4]  = '{1'b1, 1'b0, 32'hA4, 4, 1'b1, 1'b0, 1'b1, 4, 32'hA0};
    tbl[5]  = '{1'b1, 1'b1, 32'hA4, 3, 1'b0, 1'b0, 1'b1, 4, 32'hA1};
    tbl[6]  = '{1'b1, 1'b0, 32'hA4, 4, 1'b1, 1'b0, 1'b1, 4, 32'hA1};
    tbl[7]  = '{1'b0, 1'b1, 32'h00, 3, 1'b0, 1'b0, 1'b1, 4, 32'hA2};
    tbl[8]  = '{1'b0, 1'b1, 32'h00, 2, 1'b0, 1'b0, 1'b0, 4, 32'hA3};
    tbl[9]  = '{1'b0, 1'b1, 32'h00, 1, 1'b0, 1'b1, 1'b0, 4, 32'hA4};
    tbl[10] = '{1'b0, 1'b1, 32'h00, 0, 1'b0, 1'b1, 1'b0, 4, 32'h00};

    arst_n = 1'b0; din = '0; v_in = 1'b0; r_in = 1'b0; flush = 1'b0;
    afull_thr = 3'd3; aempty_thr = 3'd1;
    #3;
    chk("reset.count", o4_count, 0);
    chk("reset.wm", o4_wm, 0);
    chk("reset.valid", o4_vld, 0);
    chk("reset.ready", o4_rdy, 1);
    chk("reset.empty", o4_empty, 1);
    chk("reset.full", o4_full, 0);
    check_all();
    @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      v_in = tbl[i].v; r_in = tbl[i].r; din = tbl[i].d;
      tick();
      chk($sformatf("tbl%0d.count", i), o4_count, tbl[i].c);
      chk($sformatf("tbl%0d.full", i), o4_full, tbl[i].f);
      chk($sformatf("tbl%0d.ready", i), o4_rdy, int'(!tbl[i].f));
      chk($sformatf("tbl%0d.valid", i), o4_vld, int'(tbl[i].c != 0));
      chk($sformatf("tbl%0d.aempty", i), o4_ae, tbl[i].ae);
      chk($sformatf("tbl%0d.afull", i), o4_af, tbl[i].af);
      chk($sformatf("tbl%0d.wm", i), o4_wm, tbl[i].wm);
      if (tbl[i].c != 0) chk($sformatf("tbl%0d.data", i), int'(o4_data), int'(tbl[i].head));
    end

    // Threshold above DEPTH: almost-full must never assert.
    afull_thr = 3'd7;
    v_in = 1'b1; r_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din = 32'hB0 + i;
      tick();
      chk("afull_high", o4_af, 0);
    end
    v_in = 1'b0; r_in = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    afull_thr = 3'd3;

    // Steady streaming at count 2: count constant, one transfer per cycle.
    r_in = 1'b0; v_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din = 32'hC0 + i;
      tick();
    end
    r_in = 1'b1; hs = 0;
    for (int i = 0; i < 20; i++) begin
      din = 32'hD0 + i;
      if (o4_vld && o4_rdy) hs++;
      tick();
      chk("stream.count", o4_count, 2);
    end
    chk("stream.throughput", hs, 20);

    // Flush at count 3 with a concurrent push.
    r_in = 1'b0; din = 32'hE0;
    tick();
    chk("preflush.count", o4_count, 3);
    flush = 1'b1; din = 32'hE1;
    tick();
    flush = 1'b0;
    chk("flush.count", o4_count, 0);
    chk("flush.wm", o4_wm, 0);
    chk("flush.valid", o4_vld, 0);

    // Asynchronous reset dropped mid-burst, between clock edges.
    v_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din = 32'hF0 + i;
      tick();
    end
    r_in = 1'b1;
    #2 arst_n = 1'b0;
    #1;
    chk("arst.count", o4_count, 0);
    chk("arst.wm", o4_wm, 0);
    chk("arst.valid", o4_vld, 0);
    chk("arst.ready", o4_rdy, 1);
    chk("arst.empty", o4_empty, 1);
    chk("arst.d5count", o5_count, 0);
    check_all();
    @(negedge clk);
    v_in = 1'b0; r_in = 1'b0;
    arst_n = 1'b1;

    // Randomised traffic; the DEPTH=5 instance exercises non-power-of-two pointer wrap.
    for (int i = 0; i < 400; i++) begin
      v_in       = ($urandom_range(0, 3) != 0);
      r_in       = ($urandom_range(0, 2) != 0) && (i % 37 > 8);
      flush      = ($urandom_range(0, 59) == 0);
      din        = $urandom;
      afull_thr  = 3'($urandom_range(0, 7));
      aempty_thr = 3'($urandom_range(0, 7));
      tick();
      chk("rand.d5bound", int'(o5_count <= 3'd5), 1);
    end
    flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_top_v2.md
Name: fifo_top_v2

Overview:
Parametrised successor to fifo_top: single-clock valid/ready FIFO with generic payload type and arbitrary (non-power-of-two) depth. Adds a correctly sized occupancy count, runtime almost-full/almost-empty thresholds, synchronous flush, and a high-watermark monitor. Sits between producer/consumer stages wherever fifo_top is used today; the handshake is drop-in compatible.

Parameters:
DEPTH, 4, number of entries; legal range 2..1024; need not be a power of two.
data_t, logic [31:0], payload type; packed types only.
CW, $clog2(DEPTH+1), width of count and threshold ports; derived, not overridden.

Ports:
clk_i  in  1  clock, rising edge
arst_ni  in  1  asynchronous active-low reset
data_i  in  $bits(data_t)  write payload
data_valid_i  in  1  producer has data
data_ready_o  out  1  FIFO can accept
data_o  out  $bits(data_t)  head-of-queue payload
data_valid_o  out  1  head entry valid
data_ready_i  in  1  consumer accepts
flush_i  in  1  synchronous clear of contents
afull_thresh_i  in  CW  almost-full level
aempty_thresh_i  in  CW  almost-empty level
isFull_o  out  1  count == DEPTH
isEmpty_o  out  1  count == 0
isAlmostFull_o  out  1  count >= afull_thresh_i
isAlmostEmpty_o  out  1  count <= aempty_thresh_i
count_o  out  CW  occupancy, 0..DEPTH inclusive
watermark_o  out  CW  peak count since reset/flush

Behaviour:
- Reset (arst_ni low, async): pointers=0, count_o=0, watermark_o=0, data_valid_o=0, data_ready_o=1, isEmpty_o=1, isFull_o=0; data_o don't-care (memory not reset). Almost flags are combinational from count and thresholds.
- push = data_valid_i & data_ready_o; pop = data_valid_o & data_ready_i; both evaluated at the rising edge.
- data_ready_o = !isFull_o; data_valid_o = !isEmpty_o. Neither depends combinationally on data_ready_i/data_valid_i, so no comb path crosses the FIFO.
- Full with a pop pending: push is still refused that cycle (ready_o is low); ready_o rises the cycle after the pop.
- Empty with a push: data_valid_o rises the cycle after the push edge. Write-to-read latency is 1 cycle; no bypass.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged; both pointers advance.
- data_o = mem[rd_ptr], read combinationally; it is stable while data_valid_o=1 and data_ready_i=0.
- Pointers wrap explicitly from DEPTH-1 to 0; no reliance on power-of-two rollover.
- count: next = count + push - pop, computed in CW bits; never exceeds DEPTH.
- watermark: next = max(watermark, next count).
- flush_i=1 at an edge: pointers, count and watermark go to 0. Any push or pop in the same cycle is discarded; flush has priority. data_ready_o stays as computed (the producer may see an accepted-looking handshake that is dropped; this is documented behaviour).
- Thresholds are sampled continuously. Threshold values above DEPTH are legal: almost-full is then never asserted, and almost-empty is always asserted.
- Async reset mid-transfer aborts the transfer immediately; no partial state survives.
- Assertions (simulation only): no push while full, no pop while empty, and count_o <= DEPTH.

Decomposition:
- Package fifo_pkg: default data_t, the helper function for CW, and the DEPTH range-check constant.
- Sub-module fifo_mem: DEPTH x data_t register array, one write port, one asynchronous read port, no reset.
- fifo_top_v2 holds pointers, count, flags, watermark and flush logic.

Test Plan:
- Reset then fill, DEPTH=4: 5 pushes with ready_i=0 -> 4 accepted, count_o=4, isFull_o=1, data_ready_o=0, watermark_o=4; 5th held until space frees.
- Drain: ready_i=1 after fill -> 4 pops in FIFO order, then isEmpty_o=1 and count_o=0; watermark_o stays 4.
- DEPTH=5 (non-power-of-two): 12 push/pop pairs interleaved with random stalls -> output order matches scoreboard across pointer wrap; count_o never exceeds 5.
- Steady streaming: valid_i=1 and ready_i=1 for 20 cycles with count=2 -> count_o constant at 2 and throughput of 1 per cycle.
- Thresholds: afull=3, aempty=1 -> isAlmostEmpty_o=1 for count 0..1; isAlmostFull_o=1 for count 3..4. Set afull=7 -> isAlmostFull_o never asserts.
- Flush and reset: flush_i pulsed at count=3 with a concurrent push -> next cycle count_o=0, watermark_o=0, valid_o=0. arst_ni dropped mid-burst -> all outputs at reset values asynchronously.
